// File: rtl/uart_param_loader.sv
// Frames sync-delimited, XOR-checked parameter blocks from a UART byte stream.
// Publishes the payload only for complete frames with a good checksum.
module uart_param_loader #(
  parameter int         PARAM_BYTES    = 26,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [8*PARAM_BYTES-1:0]   params,
  output logic                       params_ready,
  output logic                       csum_error,
  output logic                       timeout_error,
  output logic                       busy
);

  localparam int W  = 8*PARAM_BYTES;
  localparam int CW = $clog2(PARAM_BYTES+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK
  } state_t;

  state_t        state;
  logic [W-1:0]  shadow;
  logic [CW-1:0] byte_cnt;
  logic [7:0]    csum;
  logic [TW-1:0] timer;

  logic [W+7:0]  shadow_shift;
  logic          timer_exp;

  assign shadow_shift = {shadow, rx_data};
  assign timer_exp    = (timer == TW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shadow        <= '0;
      byte_cnt      <= '0;
      csum          <= '0;
      timer         <= '0;
      params        <= '0;
      params_ready  <= 1'b0;
      csum_error    <= 1'b0;
      timeout_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      params_ready  <= 1'b0;
      csum_error    <= 1'b0;
      timeout_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state    <= PAYLOAD;
            byte_cnt <= '0;
            csum     <= '0;
            timer    <= '0;
            busy     <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (rx_valid) begin
            shadow <= shadow_shift[W-1:0];
            csum   <= csum ^ rx_data;
            timer  <= '0;
            if (byte_cnt == CW'(PARAM_BYTES-1))
              state <= CHECK;
            else
              byte_cnt <= byte_cnt + CW'(1);
          end else if (timer_exp) begin
            timeout_error <= 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        CHECK: begin
          if (rx_valid) begin
            if (rx_data == csum) begin
              params       <= shadow;
              params_ready <= 1'b1;
            end else begin
              csum_error <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
            timer <= '0;
          end else if (timer_exp) begin
            timeout_error <= 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_param_loader.sv
// Bench for uart_param_loader: directed frames plus random traffic,
// checked against a byte-level frame model.
module tb_uart_param_loader;

  localparam int P = 26;
  localparam int T = 50;
  localparam int W = 8*P;
  localparam logic [7:0] SYNC = 8'hA5;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic [W-1:0] params;
  logic         params_ready;
  logic         csum_error;
  logic         timeout_error;
  logic         busy;

  int passed = 0;
  int total  = 0;

  // model state
  bit           m_in_frame = 0;
  logic [7:0]   m_q[$];
  logic [W-1:0] m_params = '0;

  logic [7:0]   pl[P];
  logic [7:0]   ck;

  uart_param_loader #(
    .PARAM_BYTES(P),
    .SYNC_BYTE(SYNC),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .params(params),
    .params_ready(params_ready),
    .csum_error(csum_error),
    .timeout_error(timeout_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ev: 0 none, 1 params_ready, 2 csum_error
  task automatic feed(input logic [7:0] b, output int ev);
    logic [7:0] x;
    ev = 0;
    if (!m_in_frame) begin
      if (b == SYNC) begin
        m_in_frame = 1;
        m_q = {};
      end
    end else if (m_q.size() < P) begin
      m_q.push_back(b);
    end else begin
      x = 8'h00;
      foreach (m_q[i]) x ^= m_q[i];
      if (x == b) begin
        m_params = '0;
        foreach (m_q[i]) m_params = {m_params[W-9:0], m_q[i]};
        ev = 1;
      end else begin
        ev = 2;
      end
      m_in_frame = 0;
    end
  endtask

  task automatic check_outs(input string tag, input int ev, input bit to);
    chk({tag, ".ready"}, 256'(params_ready), 256'(ev == 1));
    chk({tag, ".csum"}, 256'(csum_error), 256'(ev == 2));
    chk({tag, ".tmo"}, 256'(timeout_error), 256'(to));
    chk({tag, ".busy"}, 256'(busy), 256'(m_in_frame));
    chk({tag, ".params"}, 256'(params), 256'(m_params));
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b);
    int ev;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    feed(b, ev);
    check_outs(tag, ev, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("idle.tmo", 256'(timeout_error), 256'(0));
    end
  endtask

  task automatic send_frame(input string tag, input int maxgap);
    send_byte({tag, ".sync"}, SYNC);
    for (int i = 0; i < P; i++) begin
      idle($urandom_range(0, maxgap));
      send_byte({tag, ".pay"}, pl[i]);
    end
    idle($urandom_range(0, maxgap));
    send_byte({tag, ".ck"}, ck);
  endtask

  function automatic logic [7:0] xor_pl();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < P; i++) x ^= pl[i];
    return x;
  endfunction

  task automatic rand_pl();
    for (int i = 0; i < P; i++) pl[i] = 8'($urandom_range(0, 255));
    ck = xor_pl();
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 1'b0);
    reset = 1'b0;
    idle(2);

    // 1: good frame 01..1A, 1B
    for (int i = 0; i < P; i++) pl[i] = 8'(i + 1);
    ck = 8'h1B;
    send_frame("t1", 0);
    chk("t1.params_lit", 256'(params[W-1:W-16]), 256'(16'h0102));
    chk("t1.params_lsb", 256'(params[7:0]), 256'(8'h1A));

    // 2: bad checksum
    ck = 8'h00;
    send_frame("t2", 1);

    // 3: leading garbage then good frame
    send_byte("t3.g0", 8'h00);
    send_byte("t3.g1", 8'hFF);
    send_byte("t3.g2", 8'h3C);
    rand_pl();
    send_frame("t3", 2);

    // 4: timeout after 10 payload bytes
    rand_pl();
    send_byte("t4.sync", SYNC);
    for (int i = 0; i < 10; i++) send_byte("t4.pay", pl[i]);
    for (int k = 1; k <= T; k++) begin
      @(posedge clk);
      #1;
      chk("t4.tmo", 256'(timeout_error), 256'(k == T));
      chk("t4.busy", 256'(busy), 256'(k < T));
    end
    m_in_frame = 0;
    idle(1);
    rand_pl();
    send_frame("t4b", 1);

    // 5: byte lands exactly as the timer expires
    rand_pl();
    send_byte("t5.sync", SYNC);
    for (int i = 0; i < P; i++) begin
      if (i == 3 || i == P - 1) idle(T - 1);
      send_byte("t5.pay", pl[i]);
    end
    idle(T - 1);
    send_byte("t5.ck", ck);

    // 6: reset mid-frame, then two back-to-back frames
    rand_pl();
    send_byte("t6.sync", SYNC);
    for (int i = 0; i < 5; i++) send_byte("t6.pay", pl[i]);
    reset = 1'b1;
    #1;
    m_in_frame = 0;
    m_params = '0;
    check_outs("t6.rst", 0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rand_pl();
    send_frame("t6a", 0);
    rand_pl();
    send_frame("t6b", 0);

    // random traffic: junk, good and corrupted frames, short gaps
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) begin
        send_byte("r.junk", 8'($urandom_range(0, 255)));
        idle($urandom_range(0, 2));
      end
      rand_pl();
      if ($urandom_range(0, 2) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      send_frame("r", 2);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
